display_scheduler: RTL

Sequencer and source arbiter for the board's 4-digit seven-segment display path. It generates the digit-scan strobe, tracks the active digit, and shares the single 16-bit display word among four CPU debug sources (pages). Pages advance on a debounced push-button or automatically. The display word changes only at frame boundaries, so a scan never shows half of one page and half of another. Outputs feed the digit multiplexer / segment decoder.

---
 rtl/display_scheduler.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/display_scheduler.sv
// Purpose: digit-scan sequencer and frame-synchronous page arbiter for a 4-digit 7-seg display.
// Latency: scan_tick SCAN_DIV cycles after reset; page change at the first frame edge after an advance.
// Backpressure: none; free-running, the downstream mux/decoder consumes outputs every cycle.
//
// Ports:
//   CLK, RST          clock, asynchronous active-low reset
//   btn_next          raw bouncing page-advance button (active-high)
//   auto_en           1 = rotate pages every AUTO_FRAMES frames
//   src0..src3        16-bit page sources
//   scan_tick         1-cycle strobe in the cycle after digit_sel changes
//   digit_sel         active digit, 0 = leftmost [15:12]
//   display           frame-stable display word
//   page              index of the source latched into display
//   frame_start       1-cycle strobe together with scan_tick when digit_sel wraps to 0
module display_scheduler #(
   parameter int SCAN_DIV    = 100000,
   parameter int DB_CYCLES   = 500000,
   parameter int AUTO_FRAMES = 256
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        btn_next,
   input  logic        auto_en,
   input  logic [15:0] src0,
   input  logic [15:0] src1,
   input  logic [15:0] src2,
   input  logic [15:0] src3,
   output logic        scan_tick,
   output logic [1:0]  digit_sel,
   output logic [15:0] display,
   output logic [1:0]  page,
   output logic        frame_start
);

   localparam int PW = (SCAN_DIV    > 1) ? $clog2(SCAN_DIV)    : 1;
   localparam int DW = (DB_CYCLES   > 1) ? $clog2(DB_CYCLES)   : 1;
   localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(AUTO_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } db_state_t;

   // ---------------------------------------------------------------
   // Scan prescaler and digit counter
   // ---------------------------------------------------------------
   logic [PW-1:0] presc;
   logic          slot_edge;
   logic          frame_edge;

   assign slot_edge  = (presc == PRESC_LAST);
   assign frame_edge = slot_edge && (digit_sel == 2'd3);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         presc       <= '0;
         scan_tick   <= 1'b0;
         digit_sel   <= 2'd0;
         frame_start <= 1'b0;
      end else begin
         scan_tick   <= slot_edge;
         frame_start <= frame_edge;
         if (slot_edge) begin
            presc     <= '0;
            digit_sel <= digit_sel + 2'd1;
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

   // ---------------------------------------------------------------
   // Button synchronizer
   // ---------------------------------------------------------------
   logic btn_meta;
   logic btn_s;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
      end else begin
         btn_meta <= btn_next;
         btn_s    <= btn_meta;
      end
   end

   // ---------------------------------------------------------------
   // Debounce FSM; press is a combinational pulse in the cycle the
   // press is accepted, so a frame edge in that same cycle consumes it.
   // ---------------------------------------------------------------
   db_state_t     db_state, db_state_nx;
   logic [DW-1:0] db_cnt, db_cnt_nx;
   logic          press;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         db_state <= IDLE;
         db_cnt   <= '0;
      end else begin
         db_state <= db_state_nx;
         db_cnt   <= db_cnt_nx;
      end
   end

   always_comb begin
      db_state_nx = db_state;
      db_cnt_nx   = db_cnt;
      press       = 1'b0;
      case (db_state)
         IDLE: begin
            if (btn_s) begin
               db_state_nx = PRESS_WAIT;
               db_cnt_nx   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               db_state_nx = IDLE;
            end else if (db_cnt == DB_LAST) begin
               db_state_nx = HELD;
               press       = 1'b1;
            end else begin
               db_cnt_nx = db_cnt + DW'(1);
            end
         end
         HELD: begin
            if (!btn_s) begin
               db_state_nx = RELEASE_WAIT;
               db_cnt_nx   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (btn_s) begin
               db_state_nx = HELD;
            end else if (db_cnt == DB_LAST) begin
               db_state_nx = IDLE;
            end else begin
               db_cnt_nx = db_cnt + DW'(1);
            end
         end
         default: db_state_nx = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Page selection; everything that changes the visible word is
   // gated by frame_edge so a scan never mixes two pages.
   // ---------------------------------------------------------------
   logic          pending;
   logic [FW-1:0] fcnt;
   logic          advance;
   logic [1:0]    page_nx;
   logic [15:0]   src_sel;

   assign advance = pending | press | (auto_en & (fcnt == FRAME_LAST));
   assign page_nx = advance ? page + 2'd1 : page;

   always_comb begin
      src_sel = src0;
      case (page_nx)
         2'd0:    src_sel = src0;
         2'd1:    src_sel = src1;
         2'd2:    src_sel = src2;
         default: src_sel = src3;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         page    <= 2'd0;
         display <= 16'h0000;
         pending <= 1'b0;
         fcnt    <= '0;
      end else if (frame_edge) begin
         page    <= page_nx;
         display <= src_sel;       // re-sampled every frame, even without a page change
         pending <= 1'b0;          // either consumed here or was already clear
         if (advance || !auto_en) begin
            fcnt <= '0;
         end else begin
            fcnt <= fcnt + FW'(1);
         end
      end else if (press) begin
         pending <= 1'b1;          // multiple presses collapse into one advance
      end
   end

endmodule
